// File: rtl/clk_sched_pkg.sv
// Shared types and default values for the programmable clock scheduler.
package clk_sched_pkg;

  localparam int PKG_CNT_W      = 16;
  localparam int PKG_BURST_W    = 8;
  localparam int PKG_DEF_PERIOD = 25;
  localparam int PKG_DEF_ON     = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/clk_period_cnt.sv
// Period counter: counts 0..period-1 while running, drives the registered
// clock output and the end-of-period tick. Outputs trail the count by one cycle.
module clk_period_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] on_cnt,
  output logic             wrap,
  output logic             clk_out,
  output logic             period_tick
);

  logic [CNT_W-1:0] cnt;

  assign wrap = run && (cnt == period - CNT_W'(1));

  // Advance the count, wrap at period-1, and register the compare results.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt         <= '0;
      clk_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      clk_out     <= run && (cnt < on_cnt);
      period_tick <= wrap;
      if (!run || wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_sched.sv
// Programmable clock scheduler: IDLE/RUN/DRAIN control, a one-deep config
// shadow register applied only at period boundaries, and burst counting.
module clk_sched
  import clk_sched_pkg::*;
#(
  parameter int CNT_W      = PKG_CNT_W,
  parameter int BURST_W    = PKG_BURST_W,
  parameter int DEF_PERIOD = PKG_DEF_PERIOD,
  parameter int DEF_ON     = PKG_DEF_ON
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_on,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic               cfg_err,
  output logic               clk_out,
  output logic               period_tick,
  output logic               busy,
  output logic               done
);

  state_t             state;
  logic [CNT_W-1:0]   act_period;
  logic [CNT_W-1:0]   act_on;
  logic [BURST_W-1:0] act_burst;
  logic [CNT_W-1:0]   sh_period;
  logic [CNT_W-1:0]   sh_on;
  logic [BURST_W-1:0] sh_burst;
  logic               sh_valid;
  logic [BURST_W-1:0] burst_cnt;

  logic running;
  logic wrap;
  logic handshake;
  logic cfg_bad;
  logic burst_end;
  logic finish;

  assign running   = (state != ST_IDLE);
  assign cfg_ready = !sh_valid;
  assign handshake = cfg_valid && !sh_valid;
  assign cfg_bad   = (cfg_period < CNT_W'(2)) || (cfg_on > cfg_period);
  assign burst_end = wrap && (act_burst != '0) &&
                     ((burst_cnt + BURST_W'(1)) == act_burst);
  assign finish    = wrap && (burst_end || (state == ST_DRAIN) || stop);

  clk_period_cnt #(
    .CNT_W (CNT_W)
  ) u_period_cnt (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .run         (running),
    .period      (act_period),
    .on_cnt      (act_on),
    .wrap        (wrap),
    .clk_out     (clk_out),
    .period_tick (period_tick)
  );

  // Control FSM, config shadow/active registers, burst counting and status pulses.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      act_period <= CNT_W'(DEF_PERIOD);
      act_on     <= CNT_W'(DEF_ON);
      act_burst  <= '0;
      sh_period  <= '0;
      sh_on      <= '0;
      sh_burst   <= '0;
      sh_valid   <= 1'b0;
      burst_cnt  <= '0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done    <= finish;
      busy    <= running;
      cfg_err <= handshake && cfg_bad;

      if (handshake && !cfg_bad) begin
        sh_period <= cfg_period;
        sh_on     <= cfg_on;
        sh_burst  <= cfg_burst;
        sh_valid  <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (sh_valid) begin
            act_period <= sh_period;
            act_on     <= sh_on;
            act_burst  <= sh_burst;
            sh_valid   <= 1'b0;
          end
          if (start) begin
            state     <= ST_RUN;
            burst_cnt <= '0;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (wrap) begin
            if (sh_valid) begin
              act_period <= sh_period;
              act_on     <= sh_on;
              act_burst  <= sh_burst;
              sh_valid   <= 1'b0;
              burst_cnt  <= '0;
            end else if (act_burst != '0) begin
              burst_cnt <= burst_cnt + BURST_W'(1);
            end
            if (finish) begin
              state     <= ST_IDLE;
              burst_cnt <= '0;
            end
          end else if ((state == ST_RUN) && stop) begin
            state <= ST_DRAIN;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_sched.sv
// Self-checking bench for clk_sched: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model.
module tb_clk_sched;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_period;
  logic [15:0] cfg_on;
  logic [7:0]  cfg_burst;
  logic        cfg_err;
  logic        clk_out;
  logic        period_tick;
  logic        busy;
  logic        done;

  clk_sched dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_on      (cfg_on),
    .cfg_burst   (cfg_burst),
    .cfg_err     (cfg_err),
    .clk_out     (clk_out),
    .period_tick (period_tick),
    .busy        (busy),
    .done        (done)
  );

  // Free-running 10-unit clock.
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: is a waveform being produced, is it winding down,
  // position within the period, periods completed, active and pending config.
  bit m_run, m_drain, m_pend;
  int m_pos, m_pcnt, m_per, m_on, m_bur;
  int p_per, p_on, p_bur;
  bit e_clk, e_tick, e_done, e_busy, e_err;

  // Per-scenario observation counters.
  int c_cycles, c_high, c_tick, c_done, c_err, done_at;
  int tick_times[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_run = 0; m_drain = 0; m_pend = 0;
    m_pos = 0; m_pcnt = 0;
    m_per = 25; m_on = 12; m_bur = 0;
    e_clk = 0; e_tick = 0; e_done = 0; e_busy = 0; e_err = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs as sampled.
  task automatic modelStep();
    bit last, fin, hs, bad;
    if (!rst_n) begin
      modelReset();
      return;
    end
    e_clk  = m_run && (m_pos < m_on);
    e_tick = m_run && (m_pos == m_per - 1);
    e_busy = m_run;
    last   = e_tick;
    hs     = cfg_valid && !m_pend;
    bad    = (int'(cfg_period) < 2) || (int'(cfg_on) > int'(cfg_period));
    e_err  = hs && bad;
    fin    = last && (((m_bur != 0) && (m_pcnt + 1 == m_bur)) || m_drain || stop);
    e_done = fin;
    if (m_run) begin
      if (last) begin
        m_pos = 0;
        if (m_pend) begin
          m_per = p_per; m_on = p_on; m_bur = p_bur; m_pend = 0; m_pcnt = 0;
        end else begin
          m_pcnt++;
        end
        if (fin) begin
          m_run = 0; m_drain = 0; m_pcnt = 0;
        end
      end else begin
        m_pos++;
        if (stop) m_drain = 1;
      end
    end else begin
      if (m_pend) begin
        m_per = p_per; m_on = p_on; m_bur = p_bur; m_pend = 0;
      end
      if (start) begin
        m_run = 1; m_pos = 0; m_pcnt = 0; m_drain = 0;
      end
    end
    if (hs && !bad) begin
      p_per = int'(cfg_period); p_on = int'(cfg_on); p_bur = int'(cfg_burst);
      m_pend = 1;
    end
  endtask

  task automatic clearCounters();
    c_cycles = 0; c_high = 0; c_tick = 0; c_done = 0; c_err = 0; done_at = -1;
    tick_times.delete();
  endtask

  // Drive one cycle of inputs, advance past the edge, and compare everything.
  task automatic applyStimulus(input bit r, input bit s, input bit p, input bit v,
                               input int per, input int on, input int bur);
    rst_n      = r;
    start      = s;
    stop       = p;
    cfg_valid  = v;
    cfg_period = 16'(per);
    cfg_on     = 16'(on);
    cfg_burst  = 8'(bur);
    @(posedge clk_in);
    #1;
    modelStep();
    checkOutput("clk_out",     32'(clk_out),     32'(e_clk));
    checkOutput("period_tick", 32'(period_tick), 32'(e_tick));
    checkOutput("done",        32'(done),        32'(e_done));
    checkOutput("busy",        32'(busy),        32'(e_busy));
    checkOutput("cfg_err",     32'(cfg_err),     32'(e_err));
    checkOutput("cfg_ready",   32'(cfg_ready),   32'(!m_pend));
    c_cycles++;
    if (clk_out === 1'b1) c_high++;
    if (period_tick === 1'b1) begin
      c_tick++;
      tick_times.push_back(c_cycles);
    end
    if (done === 1'b1) begin
      c_done++;
      done_at = c_cycles;
    end
    if (cfg_err === 1'b1) c_err++;
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int tickAt(input int idx);
    if (tick_times.size() > idx) return tick_times[idx];
    return -1;
  endfunction

  initial begin
    modelReset();
    p_per = 0; p_on = 0; p_bur = 0;
    clearCounters();

    // Reset, then default 25/12 waveform with output one cycle behind start.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("rise_not_yet", 32'(clk_out), 32'd0);
    clearCounters();
    runIdle(1);
    checkOutput("rise_after_1", 32'(clk_out), 32'd1);
    runIdle(49);
    checkOutput("def_high_cnt", 32'(c_high), 32'd24);
    checkOutput("def_tick_cnt", 32'(c_tick), 32'd2);
    checkOutput("def_tick0_at", 32'(tickAt(0)), 32'd25);
    clearCounters();
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    runIdle(30);
    checkOutput("def_stop_done", 32'(c_done), 32'd1);

    // Burst of four 10/3 periods.
    applyStimulus(1, 0, 0, 1, 10, 3, 4);
    runIdle(2);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    clearCounters();
    runIdle(45);
    checkOutput("burst_high", 32'(c_high), 32'd12);
    checkOutput("burst_ticks", 32'(c_tick), 32'd4);
    checkOutput("burst_done_n", 32'(c_done), 32'd1);
    checkOutput("burst_done_at", 32'(done_at), 32'd40);
    checkOutput("burst_busy_end", 32'(busy), 32'd0);

    // Reconfigure mid-period: current 25-cycle period completes, then 8.
    applyStimulus(1, 0, 0, 1, 25, 12, 0);
    runIdle(2);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    runIdle(5);
    clearCounters();
    applyStimulus(1, 0, 0, 1, 8, 4, 0);
    runIdle(30);
    checkOutput("reload_tick0", 32'(tickAt(0)), 32'd20);
    checkOutput("reload_tick1", 32'(tickAt(1)), 32'd28);

    // Rejected configs leave the 8/4 waveform untouched.
    clearCounters();
    applyStimulus(1, 0, 0, 1, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 8, 9, 0);
    checkOutput("reject_err_cnt", 32'(c_err), 32'd2);
    clearCounters();
    runIdle(16);
    checkOutput("reject_high", 32'(c_high), 32'd8);
    checkOutput("reject_ticks", 32'(c_tick), 32'd2);
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    runIdle(12);

    // Stop at count 3 of a 10/3 period; start during drain has no effect.
    applyStimulus(1, 0, 0, 1, 10, 3, 0);
    runIdle(2);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    runIdle(3);
    clearCounters();
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    runIdle(18);
    checkOutput("drain_done_n", 32'(c_done), 32'd1);
    checkOutput("drain_done_at", 32'(done_at), 32'd7);
    checkOutput("drain_high", 32'(c_high), 32'd0);

    // Reset mid-period with a pending config: no done, defaults restored.
    applyStimulus(1, 0, 0, 1, 25, 12, 0);
    runIdle(2);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    runIdle(5);
    applyStimulus(1, 0, 0, 1, 8, 4, 0);
    clearCounters();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_clk_low", 32'(clk_out), 32'd0);
    runIdle(5);
    checkOutput("rst_no_done", 32'(c_done), 32'd0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    clearCounters();
    runIdle(50);
    checkOutput("rst_def_high", 32'(c_high), 32'd24);
    checkOutput("rst_def_tick", 32'(tickAt(0)), 32'd25);
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    runIdle(30);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int per, on;
      per = int'($urandom_range(0, 14));
      on  = int'($urandom_range(0, per + 1));
      applyStimulus($urandom_range(0, 199) != 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 11) == 0,
                    $urandom_range(0, 4) == 0,
                    per, on, int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
